reg_access_agent: RTL

- Initiator-side client of the locking physical register file. One agent serves one issue slot and owns exactly three register-file ports: port 0 reads rs, port 1 reads rt, port 2 writes rd.
- Per instruction it performs: latch issue command → request locks → wait for all grants → capture operands → hand operands to execution → accept result → commit write → release locks.
- It sits between the issue/dispatch stage and the register file's per-port request/grant interface.

---
 rtl/reg_access_agent.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/reg_access_agent.sv
// ---------------------------------------------------------------------------
// reg_access_agent
//
// Issue-slot client of the locking physical register file. For each accepted
// instruction it locks rs/rt (read ports 0/1) and rd (write port 2), captures
// the source operands as their grants arrive, hands them to execution, takes
// the result back, commits it to rd and finally releases every held lock.
// One instruction is in flight at a time.
//
// Optional build macro: REG_AGENT_TIMEOUT_EN
//   When defined, adds a saturating watchdog on the acquire phase and the
//   sticky output timeout_err. The FSM never aborts on timeout.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   issue_*                 issue command (valid/ready, id, enables, addresses)
//   port_addr/req_*/...     per-port request side towards the register file
//                           (index 0 = rs read, 1 = rt read, 2 = rd write)
//   port_rdata_in/grant_in  per-port read data and grant from the register file
//   op_valid/op_ready/op_a/op_b   operand handoff to execution
//   res_valid/res_ready/res_data  result from execution
//   busy                    agent is not idle
//   timeout_err             (REG_AGENT_TIMEOUT_EN only) acquire watchdog fired
// ---------------------------------------------------------------------------
module reg_access_agent #(
    parameter  int NUM_PHY_REGS   = 32,
    parameter  int ID_WIDTH       = 4,
    parameter  int TIMEOUT_CYCLES = 1024,
    localparam int AW             = $clog2(NUM_PHY_REGS)
) (
    input  logic                     clk,
    input  logic                     rst_n,

    input  logic                     issue_valid,
    output logic                     issue_ready,
    input  logic [ID_WIDTH-1:0]      issue_id,
    input  logic                     issue_rs_en,
    input  logic                     issue_rt_en,
    input  logic                     issue_rd_en,
    input  logic [AW-1:0]            issue_rs_addr,
    input  logic [AW-1:0]            issue_rt_addr,
    input  logic [AW-1:0]            issue_rd_addr,

    output logic [2:0][AW-1:0]       port_addr,
    output logic [2:0]               port_req_read,
    output logic [2:0]               port_req_write,
    output logic [2:0]               port_write_commit,
    output logic [2:0][ID_WIDTH-1:0] port_issue_id,
    output logic [2:0]               port_release,
    output logic [2:0][31:0]         port_wdata,
    input  logic [2:0][31:0]         port_rdata_in,
    input  logic [2:0]               port_grant_in,

    output logic                     op_valid,
    input  logic                     op_ready,
    output logic [31:0]              op_a,
    output logic [31:0]              op_b,

    input  logic                     res_valid,
    output logic                     res_ready,
    input  logic [31:0]              res_data,

    output logic                     busy
`ifdef REG_AGENT_TIMEOUT_EN
    ,
    output logic                     timeout_err
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACQUIRE,
        S_DISPATCH,
        S_WAIT_RES,
        S_COMMIT,
        S_RELEASE
    } state_t;

    state_t                     state_q, state_d;

    logic [ID_WIDTH-1:0]        id_q;
    logic [2:0]                 en_q;       // {rd, rt, rs}
    logic [2:0][AW-1:0]         addr_q;
    logic [2:0]                 granted_q;  // sticky: first grant seen per port
    logic [31:0]                op_a_q;
    logic [31:0]                op_b_q;
    logic [31:0]                res_q;

    logic                       accept;
    logic                       all_granted;

    // Port 2 is write-only; its read data is never consumed.
    logic                       unused_rdata;
    assign unused_rdata = ^port_rdata_in[2];

    assign accept = (state_q == S_IDLE) && issue_valid;

    // A port counts as satisfied if it is disabled, was granted earlier, or is
    // being granted right now (so ACQUIRE can finish in a single cycle).
    assign all_granted = &(granted_q | port_grant_in | ~en_q);

    // ---- state register ---------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---- next state and outputs (decoded from registered state only) ------
    always_comb begin
        state_d           = state_q;
        issue_ready       = 1'b0;
        op_valid          = 1'b0;
        res_ready         = 1'b0;
        port_req_read     = '0;
        port_req_write    = '0;
        port_write_commit = '0;
        port_release      = '0;
        port_addr         = '0;
        port_wdata        = '0;
        port_issue_id     = {3{id_q}};
        busy              = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                issue_ready = 1'b1;
                if (issue_valid) begin
                    state_d = S_ACQUIRE;
                end
            end
            S_ACQUIRE: begin
                if (all_granted) begin
                    state_d = S_DISPATCH;
                end
            end
            S_DISPATCH: begin
                op_valid = 1'b1;
                if (op_ready) begin
                    state_d = S_WAIT_RES;
                end
            end
            S_WAIT_RES: begin
                res_ready = 1'b1;
                if (res_valid) begin
                    state_d = en_q[2] ? S_COMMIT : S_RELEASE;
                end
            end
            S_COMMIT: begin
                port_write_commit[2] = 1'b1;
                state_d              = S_RELEASE;
            end
            S_RELEASE: begin
                port_release = en_q;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Locks are held from ACQUIRE through RELEASE inclusive.
        if (state_q != S_IDLE) begin
            port_req_read[0]  = en_q[0];
            port_req_read[1]  = en_q[1];
            port_req_write[2] = en_q[2];
            for (int p = 0; p < 3; p++) begin
                port_addr[p] = en_q[p] ? addr_q[p] : '0;
            end
        end
        port_wdata[2] = res_q;
    end

    // ---- command latch, grant tracking and operand/result capture ---------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_q      <= '0;
            en_q      <= '0;
            addr_q    <= '0;
            granted_q <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            res_q     <= '0;
        end else begin
            if (accept) begin
                id_q      <= issue_id;
                en_q      <= {issue_rd_en, issue_rt_en, issue_rs_en};
                addr_q[0] <= issue_rs_addr;
                addr_q[1] <= issue_rt_addr;
                addr_q[2] <= issue_rd_addr;
                granted_q <= '0;
                // Disabled operands must read as zero.
                op_a_q    <= '0;
                op_b_q    <= '0;
            end

            // Only the first grant on each port matters; read data is taken
            // in that same cycle and later grant drops are ignored.
            if (state_q == S_ACQUIRE) begin
                if (en_q[0] && port_grant_in[0] && !granted_q[0]) begin
                    granted_q[0] <= 1'b1;
                    op_a_q       <= port_rdata_in[0];
                end
                if (en_q[1] && port_grant_in[1] && !granted_q[1]) begin
                    granted_q[1] <= 1'b1;
                    op_b_q       <= port_rdata_in[1];
                end
                if (en_q[2] && port_grant_in[2] && !granted_q[2]) begin
                    granted_q[2] <= 1'b1;
                end
            end

            if ((state_q == S_WAIT_RES) && res_valid) begin
                res_q <= res_data;
            end
        end
    end

    assign op_a = op_a_q;
    assign op_b = op_b_q;

`ifdef REG_AGENT_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    // wait_cnt_q holds the ordinal of the ACQUIRE cycle in progress, so the
    // error becomes visible during the TIMEOUT_CYCLES-th waiting cycle.
    logic [CW-1:0] wait_cnt_q;
    logic          timeout_q;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v >= CW'(TIMEOUT_CYCLES)) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            if (accept) begin
                wait_cnt_q <= CW'(1);
            end else if (state_q == S_ACQUIRE) begin
                wait_cnt_q <= sat_inc(wait_cnt_q);
                if (sat_inc(wait_cnt_q) >= CW'(TIMEOUT_CYCLES)) begin
                    timeout_q <= 1'b1;
                end
            end
        end
    end

    assign timeout_err = timeout_q;
`endif

endmodule
